// File: rtl/mem_access_ctrl_pkg.sv
// Opcode encodings shared with the execute stage plus access-classification helpers
// used by the load/store controller and its store aligner.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    // Opcode and byte offset travel together from acceptance to completion.
    typedef struct packed {
        logic [5:0] opcode;
        logic [1:0] offset;
    } acc_tag_t;

    function automatic acc_size_e op_size(input logic [5:0] op);
        acc_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            OP_LW, OP_SW:         sz = SZ_WORD;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Illegal opcodes are reported through the same fault path as misalignment.
    function automatic logic op_faults(input logic [5:0] op, input logic [1:0] off);
        logic f;
        case (op_size(op))
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = off[0];
            SZ_WORD: f = |off;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Big-endian store lane steering: byte enables and replicated write data from opcode and offset.
// Purely combinational; loads and illegal opcodes produce no enables and zero data.
module mem_store_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_aligned
);

    always_comb begin
        be            = 4'b0000;
        wdata_aligned = 32'h0000_0000;
        case (opcode)
            OP_SB: begin
                // Offset 0 is the most significant byte lane.
                be            = 4'b1000 >> offset;
                wdata_aligned = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be            = offset[1] ? 4'b0011 : 4'b1100;
                wdata_aligned = {2{wdata[15:0]}};
            end
            OP_SW: begin
                be            = 4'b1111;
                wdata_aligned = wdata;
            end
            default: begin
                be            = 4'b0000;
                wdata_aligned = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between execute and data memory: one access in flight, word-aligned
// request on a ready/valid port, load wait bounded by a timeout, one-cycle completion pulse.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [5:0]  rsp_opcode,
    output logic [1:0]  rsp_byte_offset,
    output logic        rsp_misalign,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_tag_t         tag_q, tag_d;

    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    acc_tag_t         rsp_tag_q, rsp_tag_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_misalign_q, rsp_misalign_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic [3:0]       align_be;
    logic [31:0]      align_wdata;
    logic             req_fault;

    mem_store_align u_store_align (
        .opcode        (req_opcode),
        .offset        (req_addr[1:0]),
        .wdata         (req_wdata),
        .be            (align_be),
        .wdata_aligned (align_wdata)
    );

    assign req_fault = op_faults(req_opcode, req_addr[1:0]);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tag_d          = tag_q;
        mem_addr_d     = mem_addr_q;
        mem_we_d       = mem_we_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        rsp_tag_d      = rsp_tag_q;
        rsp_data_d     = rsp_data_q;
        rsp_misalign_d = rsp_misalign_q;
        rsp_timeout_d  = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d.opcode = req_opcode;
                    tag_d.offset = req_addr[1:0];
                    if (req_fault) begin
                        // Faulting accesses never reach memory.
                        state_d        = S_DONE;
                        rsp_tag_d      = tag_d;
                        rsp_data_d     = 32'h0000_0000;
                        rsp_misalign_d = 1'b1;
                        rsp_timeout_d  = 1'b0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_we_d    = op_is_store(req_opcode);
                        mem_be_d    = align_be;
                        mem_wdata_d = align_wdata;
                    end
                end
            end

            S_ISSUE: begin
                if (mem_req_ready) begin
                    if (mem_we_q) begin
                        state_d        = S_DONE;
                        rsp_tag_d      = tag_q;
                        rsp_data_d     = 32'h0000_0000;
                        rsp_misalign_d = 1'b0;
                        rsp_timeout_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_RSP;
                        cnt_d   = '0;
                    end
                end
            end

            S_WAIT_RSP: begin
                // A reply arriving on the last counted cycle still beats the timeout.
                if (mem_rsp_valid) begin
                    state_d        = S_DONE;
                    rsp_tag_d      = tag_q;
                    rsp_data_d     = mem_rsp_data;
                    rsp_misalign_d = 1'b0;
                    rsp_timeout_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = S_DONE;
                    rsp_tag_d      = tag_q;
                    rsp_data_d     = 32'h0000_0000;
                    rsp_misalign_d = 1'b0;
                    rsp_timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            tag_q          <= '0;
            mem_addr_q     <= 32'h0000_0000;
            mem_we_q       <= 1'b0;
            mem_be_q       <= 4'b0000;
            mem_wdata_q    <= 32'h0000_0000;
            rsp_tag_q      <= '0;
            rsp_data_q     <= 32'h0000_0000;
            rsp_misalign_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tag_q          <= tag_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            rsp_tag_q      <= rsp_tag_d;
            rsp_data_q     <= rsp_data_d;
            rsp_misalign_q <= rsp_misalign_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign mem_req_valid   = (state_q == S_ISSUE);
    assign rsp_valid       = (state_q == S_DONE);

    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_we_q;
    assign mem_be          = mem_be_q;
    assign mem_wdata       = mem_wdata_q;

    assign rsp_data        = rsp_data_q;
    assign rsp_opcode      = rsp_tag_q.opcode;
    assign rsp_byte_offset = rsp_tag_q.offset;
    assign rsp_misalign    = rsp_misalign_q;
    assign rsp_timeout     = rsp_timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a per-access timeline model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TMO   = 256;
    localparam int NCYC  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = 6'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_opcode;
    logic [1:0]  rsp_byte_offset;
    logic        rsp_misalign;
    logic        rsp_timeout;
    logic        busy;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
        .rsp_byte_offset(rsp_byte_offset), .rsp_misalign(rsp_misalign),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Expected timeline, indexed by cycle number.
    bit exp_busy [NCYC];
    bit exp_mreq [NCYC];
    bit exp_rvld [NCYC];
    logic [31:0] exp_m_addr, exp_m_wd, exp_r_data;
    logic [3:0]  exp_m_be;
    logic        exp_m_we, exp_r_mis, exp_r_to;
    logic [5:0]  exp_r_op;
    logic [1:0]  exp_r_off;
    // Values the rsp_* outputs must hold while idle.
    logic [31:0] last_data = 0;
    logic [5:0]  last_op = 0;
    logic [1:0]  last_off = 0;
    logic        last_mis = 0, last_to = 0;

    // Observations for literal checks.
    int          obs_done = -1, obs_rvld_cnt = 0, obs_mreq_cnt = 0;
    logic [31:0] obs_rdata, obs_maddr, obs_mwd;
    logic [3:0]  obs_mbe;
    logic        obs_mwe, obs_mis, obs_to;
    logic [1:0]  obs_off;

    task automatic plan(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int a, input int rwait, input int pwait, input logic [31:0] rdata,
                        output int done, output int r, output int p);
        int sz;
        int off;
        logic st, flt;
        logic [31:0] part;
        off = int'(addr[1:0]);
        p = -1;
        r = -1;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = 1;
            OP_LH, OP_LHU, OP_SH: sz = 2;
            OP_LW, OP_SW:         sz = 4;
            default:              sz = 0;
        endcase
        st  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        flt = (sz == 0) ? 1'b1 : ((off % sz) != 0);
        exp_r_op = op; exp_r_off = addr[1:0]; exp_r_mis = flt; exp_r_to = 1'b0; exp_r_data = 0;
        if (flt) begin
            done = a + 1;
        end else begin
            r = a + 1 + rwait;
            for (int k = a + 1; k <= r; k++) exp_mreq[k] = 1'b1;
            exp_m_addr = addr & 32'hFFFF_FFFC;
            exp_m_we   = st;
            exp_m_be   = 4'b0000;
            exp_m_wd   = 32'h0;
            if (st) begin
                for (int i = 0; i < sz; i++) exp_m_be[3 - (off + i)] = 1'b1;
                part = (sz == 4) ? wdata : (wdata & ((32'd1 << (8 * sz)) - 1));
                for (int i = 0; i < 4 / sz; i++) exp_m_wd = exp_m_wd | (part << (8 * sz * i));
                done = r + 1;
            end else if (pwait >= 1 && pwait <= TMO) begin
                p = r + pwait;
                done = p + 1;
                exp_r_data = rdata;
            end else begin
                done = r + TMO + 1;
                exp_r_to = 1'b1;
                if (pwait >= 1) p = r + pwait;
            end
        end
        for (int k = a + 1; k <= done; k++) exp_busy[k] = 1'b1;
        exp_rvld[done] = 1'b1;
    endtask

    task automatic model_reset(input int c);
        for (int k = c; k < NCYC; k++) begin
            exp_busy[k] = 1'b0; exp_mreq[k] = 1'b0; exp_rvld[k] = 1'b0;
        end
        last_data = 0; last_op = 0; last_off = 0; last_mis = 0; last_to = 0;
    endtask

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < NCYC) begin
            chk("busy", busy, exp_busy[c]);
            chk("req_ready", req_ready, !exp_busy[c]);
            chk("mem_req_valid", mem_req_valid, exp_mreq[c]);
            chk("rsp_valid", rsp_valid, exp_rvld[c]);
            if (exp_mreq[c]) begin
                chk("mem_addr", mem_addr, exp_m_addr);
                chk("mem_we", mem_we, exp_m_we);
                chk("mem_be", mem_be, exp_m_be);
                if (exp_m_we) chk("mem_wdata", mem_wdata, exp_m_wd);
            end
            if (exp_rvld[c]) begin
                chk("rsp_data", rsp_data, exp_r_data);
                chk("rsp_opcode", rsp_opcode, exp_r_op);
                chk("rsp_off", rsp_byte_offset, exp_r_off);
                chk("rsp_misalign", rsp_misalign, exp_r_mis);
                chk("rsp_timeout", rsp_timeout, exp_r_to);
                last_data = exp_r_data; last_op = exp_r_op; last_off = exp_r_off;
                last_mis = exp_r_mis; last_to = exp_r_to;
            end else if (!exp_busy[c]) begin
                chk("hold_data", rsp_data, last_data);
                chk("hold_opcode", rsp_opcode, last_op);
                chk("hold_off", rsp_byte_offset, last_off);
                chk("hold_flags", {rsp_misalign, rsp_timeout}, {last_mis, last_to});
            end
        end
        if (mem_req_valid) begin
            obs_mreq_cnt++;
            obs_maddr = mem_addr; obs_mbe = mem_be; obs_mwd = mem_wdata; obs_mwe = mem_we;
        end
        if (rsp_valid) begin
            obs_rvld_cnt++;
            obs_done = c; obs_rdata = rsp_data; obs_mis = rsp_misalign;
            obs_to = rsp_timeout; obs_off = rsp_byte_offset;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access; returns its accept cycle.
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input int rwait, input int pwait, input logic [31:0] rdata,
                             output int a);
        int done, r, p, last_c;
        a = cyc;
        plan(op, addr, wdata, a, rwait, pwait, rdata, done, r, p);
        last_c = ((p > done) ? p : done) + 1;
        req_opcode = op; req_addr = addr; req_wdata = wdata;
        for (int k = a; k <= last_c; k++) begin
            req_valid     = (k == a);
            mem_req_ready = (k == r);
            mem_rsp_valid = (p >= 0) && (k == p);
            mem_rsp_data  = (k == p) ? rdata : 32'h5A5A_0F0F;
            step();
        end
        req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, r, p, m0, v0;
        repeat (3) step();
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
        chk("reset_rsp", {rsp_valid, rsp_misalign, rsp_timeout, rsp_data}, 0);
        rst_n = 1'b1;
        step();

        do_access(OP_LW, 32'h0000_0100, 32'h0, 0, 1, 32'hDEAD_BEEF, a);
        chk("t1_latency", obs_done - a, 3);
        chk("t1_data", obs_rdata, 32'hDEAD_BEEF);
        chk("t1_off", obs_off, 2'd0);

        do_access(OP_SB, 32'h0000_0203, 32'h0000_00A5, 0, -1, 0, a);
        chk("t2_latency", obs_done - a, 2);
        chk("t2_addr", obs_maddr, 32'h0000_0200);
        chk("t2_be", obs_mbe, 4'b0001);
        chk("t2_wdata", obs_mwd, 32'hA5A5_A5A5);
        chk("t2_we", obs_mwe, 1'b1);

        m0 = obs_mreq_cnt;
        do_access(OP_SH, 32'h0000_0202, 32'h0000_1234, 5, -1, 0, a);
        chk("t3_mreq_cycles", obs_mreq_cnt - m0, 6);
        chk("t3_be", obs_mbe, 4'b0011);
        chk("t3_wdata", obs_mwd, 32'h1234_1234);

        m0 = obs_mreq_cnt;
        do_access(OP_LH, 32'h0000_0101, 32'h0, 0, -1, 0, a);
        chk("t4_latency", obs_done - a, 1);
        chk("t4_misalign", obs_mis, 1'b1);
        chk("t4_no_mreq", obs_mreq_cnt - m0, 0);

        v0 = obs_rvld_cnt;
        do_access(OP_LBU, 32'h0000_0105, 32'h0, 0, TMO + 3, 32'h7777_7777, a);
        chk("t5_latency", obs_done - a, TMO + 2);
        chk("t5_timeout", obs_to, 1'b1);
        chk("t5_data", obs_rdata, 32'h0);
        chk("t5_one_rsp", obs_rvld_cnt - v0, 1);

        do_access(OP_LHU, 32'h0000_010E, 32'h0, 0, TMO, 32'h0000_CAFE, a);
        chk("rsp_wins_timeout", obs_to, 1'b0);
        chk("rsp_wins_data", obs_rdata, 32'h0000_CAFE);
        do_access(OP_LB, 32'h0000_0107, 32'h0, 1, TMO + 1, 32'h1111_2222, a);
        chk("late_by_one_timeout", obs_to, 1'b1);

        do_access(OP_SW, 32'h0000_040C, 32'h8765_4321, 2, -1, 0, a);
        chk("sw_be", obs_mbe, 4'b1111);
        do_access(OP_SB, 32'h0000_0400, 32'h1234_56C3, 0, -1, 0, a);
        chk("sb0_be", obs_mbe, 4'b1000);
        do_access(OP_SH, 32'h0000_0400, 32'hFFFF_BEEF, 0, -1, 0, a);
        chk("sh0_wdata", obs_mwd, 32'hBEEF_BEEF);
        do_access(6'h3F, 32'h0000_0400, 32'h0, 0, -1, 0, a);
        chk("illegal_op", obs_mis, 1'b1);
        do_access(OP_LW, 32'h0000_0102, 32'h0, 0, 1, 0, a);
        do_access(OP_SW, 32'h0000_0401, 32'h0, 0, -1, 0, a);
        do_access(OP_LH, 32'h0000_0102, 32'h0, 3, 4, 32'hABCD_0123, a);
        chk("lh_off", obs_off, 2'd2);

        // Reset while waiting for load data.
        v0 = obs_rvld_cnt;
        a = cyc;
        plan(OP_LW, 32'h0000_0500, 32'h0, a, 0, -1, 0, d, r, p);
        req_opcode = OP_LW; req_addr = 32'h0000_0500; req_valid = 1'b1;
        step();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        model_reset(cyc);
        #1;
        chk("t6_req_ready", req_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_0000;
        step();
        mem_rsp_valid = 1'b0;
        step();
        chk("t6_no_rsp", obs_rvld_cnt - v0, 0);
        do_access(OP_LW, 32'h0000_0304, 32'h0, 0, 2, 32'h1122_3344, a);
        chk("t6_next_latency", obs_done - a, 4);
        chk("t6_next_data", obs_rdata, 32'h1122_3344);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
